seq_divider: RTL and testbench

Sequential radix-2 signed integer divider. It is the responder end of the dividend/divisor/dout stream handshake that the FU divide unit drives, and it replaces the vendor divider IP in that socket. It accepts one operand pair, iterates one quotient bit per cycle, and returns `{quotient, remainder}` on a single-cycle result strobe.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_step.sv | 31 +++
 rtl/seq_divider.sv | 156 +++++++++++++++
 tb/tb_seq_divider.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM states, default width
// and the field layout of the {quotient, remainder} result bus.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int QUO_LSB   = DIV_WIDTH;
    localparam int REM_LSB   = 0;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SIGN,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step on unsigned magnitudes: shift {rem, quo} left
// by one, try subtracting the divisor, keep the difference if it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvsr,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] rem_shift;
    logic           fits;

    // The shifted remainder carries one extra bit so the trial subtraction
    // never loses the bit shifted out of the top; when the divisor fits, the
    // difference is smaller than the divisor and so fits back in WIDTH bits.
    always_comb begin
        rem_shift = {rem, quo[WIDTH-1]};
        fits      = (rem_shift >= {1'b0, dvsr});
        if (fits) begin
            rem_next = rem_shift[WIDTH-1:0] - dvsr;
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = rem_shift[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential radix-2 signed divider with stream-style operand handshake and a
// single-cycle result strobe carrying {quotient, remainder}.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_axis_dividend_tvalid,
    input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
    output logic               s_axis_dividend_tready,
    input  logic               s_axis_divisor_tvalid,
    input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
    output logic               s_axis_divisor_tready,
    output logic               m_axis_dout_tvalid,
    output logic [2*WIDTH-1:0] m_axis_dout_tdata
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t         state;
    div_state_t         state_next;

    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   dvsr_q;
    logic [WIDTH-1:0]   dividend_q;
    logic               neg_quo_q;
    logic               neg_rem_q;
    logic               zero_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] tdata_q;

    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;
    logic [WIDTH-1:0]   quo_final;
    logic [WIDTH-1:0]   rem_final;
    logic               accept;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .dvsr     (dvsr_q),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    // A division starts only when both operands are offered while idle.
    assign accept = (state == IDLE) && s_axis_dividend_tvalid && s_axis_divisor_tvalid;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs decoded from the current state.
    always_comb begin
        state_next             = state;
        s_axis_dividend_tready = 1'b0;
        s_axis_divisor_tready  = 1'b0;
        m_axis_dout_tvalid     = 1'b0;
        case (state)
            IDLE: begin
                s_axis_dividend_tready = 1'b1;
                s_axis_divisor_tready  = 1'b1;
                if (accept) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (cnt_q == '0) begin
                    state_next = SIGN;
                end
            end
            SIGN: begin
                state_next = DONE;
            end
            DONE: begin
                m_axis_dout_tvalid = 1'b1;
                state_next         = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sign correction: most-negative / -1 needs no special case because the
    // unsigned quotient 2^(W-1) already reads back as most-negative in W bits.
    always_comb begin
        if (zero_q) begin
            quo_final = '1;
            rem_final = dividend_q;
        end else begin
            quo_final = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
            rem_final = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
        end
    end

    // Operand capture, one quotient bit per CALC cycle, and result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q      <= '0;
            quo_q      <= '0;
            dvsr_q     <= '0;
            dividend_q <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            zero_q     <= 1'b0;
            cnt_q      <= '0;
            tdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rem_q      <= '0;
                        quo_q      <= s_axis_dividend_tdata[WIDTH-1]
                                      ? (~s_axis_dividend_tdata + 1'b1)
                                      : s_axis_dividend_tdata;
                        dvsr_q     <= s_axis_divisor_tdata[WIDTH-1]
                                      ? (~s_axis_divisor_tdata + 1'b1)
                                      : s_axis_divisor_tdata;
                        dividend_q <= s_axis_dividend_tdata;
                        neg_quo_q  <= s_axis_dividend_tdata[WIDTH-1] ^ s_axis_divisor_tdata[WIDTH-1];
                        neg_rem_q  <= s_axis_dividend_tdata[WIDTH-1];
                        zero_q     <= (s_axis_divisor_tdata == '0);
                        cnt_q      <= CNT_W'(WIDTH - 1);
                    end
                end
                CALC: begin
                    rem_q <= rem_step;
                    quo_q <= quo_step;
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                SIGN: begin
                    tdata_q[REM_LSB +: WIDTH] <= rem_final;
                    tdata_q[WIDTH +: WIDTH]   <= quo_final;
                end
                default: begin
                end
            endcase
        end
    end

    assign m_axis_dout_tdata = tdata_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed test of seq_divider: signed results, divide-by-zero, overflow,
// fixed latency, single strobe, partial valid and mid-operation reset.
module tb_seq_divider;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           dvd_valid;
    logic [W-1:0]   dvd_data;
    logic           dvd_ready;
    logic           dvs_valid;
    logic [W-1:0]   dvs_data;
    logic           dvs_ready;
    logic           dout_valid;
    logic [2*W-1:0] dout_data;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    seq_divider #(
        .WIDTH (W)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .s_axis_dividend_tvalid (dvd_valid),
        .s_axis_dividend_tdata  (dvd_data),
        .s_axis_dividend_tready (dvd_ready),
        .s_axis_divisor_tvalid  (dvs_valid),
        .s_axis_divisor_tdata   (dvs_data),
        .s_axis_divisor_tready  (dvs_ready),
        .m_axis_dout_tvalid     (dout_valid),
        .m_axis_dout_tdata      (dout_data)
    );

    // Counts one comparison and reports it when observed and expected differ.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Advance one clock and settle just past the rising edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Initiator-style division: valids held until the strobe is seen, then
    // dropped on the following edge.
    task automatic applyStimulus(input string tag, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                                 input logic [W-1:0] exp_q, input logic [W-1:0] exp_r);
        int   n;
        logic ready_seen;
        dvd_data  = dvd;
        dvs_data  = dvs;
        dvd_valid = 1'b1;
        dvs_valid = 1'b1;
        stepCycle();
        n          = 0;
        ready_seen = 1'b0;
        while (!dout_valid && n < 100) begin
            if (dvd_ready || dvs_ready) ready_seen = 1'b1;
            stepCycle();
            n++;
        end
        if (dvd_ready || dvs_ready) ready_seen = 1'b1;
        checkOutput({tag, " latency"}, 64'(n), 64'(W + 1));
        checkOutput({tag, " tready low while busy"}, 64'(ready_seen), 64'd0);
        checkOutput({tag, " result"}, dout_data, {exp_q, exp_r});
        stepCycle();
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
        checkOutput({tag, " strobe single cycle"}, 64'(dout_valid), 64'd0);
        checkOutput({tag, " tready after done"}, 64'({dvd_ready, dvs_ready}), 64'b11);
        checkOutput({tag, " result held"}, dout_data, {exp_q, exp_r});
    endtask

    initial begin
        int   strobes;
        logic busy_seen;

        rst_n     = 1'b0;
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
        dvd_data  = '0;
        dvs_data  = '0;
        stepCycle();
        stepCycle();
        rst_n = 1'b1;
        checkOutput("reset tvalid", 64'(dout_valid), 64'd0);
        checkOutput("reset tdata", dout_data, 64'd0);
        checkOutput("reset tready", 64'({dvd_ready, dvs_ready}), 64'b11);

        applyStimulus("100/7",   32'd100,        32'd7,          32'd14,         32'd2);
        applyStimulus("-100/7",  32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE);
        applyStimulus("100/-7",  32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2);
        applyStimulus("-100/-7", 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE);
        applyStimulus("5/0",     32'd5,          32'd0,          32'hFFFFFFFF,   32'd5);
        applyStimulus("-5/0",    32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB);
        applyStimulus("min/-1",  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0);
        applyStimulus("0/3",     32'd0,          32'd3,          32'd0,          32'd0);
        applyStimulus("7/100",   32'd7,          32'd100,        32'd0,          32'd7);
        applyStimulus("max/1",   32'h7FFFFFFF,   32'd1,          32'h7FFFFFFF,   32'd0);

        // Dividend valid on its own must never start a division.
        dvd_data  = 32'd9;
        dvd_valid = 1'b1;
        busy_seen = 1'b0;
        strobes   = 0;
        for (int i = 0; i < 10; i++) begin
            stepCycle();
            if (!dvd_ready || !dvs_ready) busy_seen = 1'b1;
            if (dout_valid) strobes++;
        end
        dvd_valid = 1'b0;
        checkOutput("dividend alone no accept", 64'(busy_seen), 64'd0);
        checkOutput("dividend alone no strobe", 64'(strobes), 64'd0);

        // Reset during CALC abandons the division silently.
        rst_n     = 1'b1;
        dvd_data  = 32'd1000;
        dvs_data  = 32'd3;
        dvd_valid = 1'b1;
        dvs_valid = 1'b1;
        stepCycle();
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
        repeat (14) stepCycle();
        rst_n = 1'b0;
        stepCycle();
        rst_n = 1'b1;
        checkOutput("mid reset tdata", dout_data, 64'd0);
        checkOutput("mid reset tready", 64'({dvd_ready, dvs_ready}), 64'b11);
        strobes = 0;
        for (int i = 0; i < 40; i++) begin
            if (dout_valid) strobes++;
            stepCycle();
        end
        checkOutput("mid reset no strobe", 64'(strobes), 64'd0);
        checkOutput("mid reset tdata stays", dout_data, 64'd0);

        applyStimulus("after reset 1000/3", 32'd1000, 32'd3, 32'd333, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
